// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_unit_pkg: shared state encoding and constants for fetch.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0004;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_next_pc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_next_pc: redirect-priority mux (exc > branch > jump) and PC+4.  |
// | exc path present only when IF_EXC_VECTOR_EN is defined.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module if_next_pc
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
`ifdef IF_EXC_VECTOR_EN
  input  logic        exc,
  input  logic [31:0] exc_vector,
`endif
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] seq_pc
);

  assign seq_pc = word_align(pc) + 32'd4;

  // Later assignments override earlier ones, giving the priority order.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = NOP;
    if (jump) begin
      redirect    = 1'b1;
      redirect_pc = word_align(jump_target);
    end
    if (branch_taken) begin
      redirect    = 1'b1;
      redirect_pc = word_align(branch_target);
    end
`ifdef IF_EXC_VECTOR_EN
    if (exc) begin
      redirect    = 1'b1;
      redirect_pc = word_align(exc_vector);
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_unit: instruction fetch FSM (RST/FETCH/HOLD) with redirect |
// | handling across memory wait states. Macro: IF_EXC_VECTOR_EN.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_Inst,
  output logic [31:0] IF_PC_Plus4,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
  logic         imem_req_q, imem_req_d;
  logic         fetch_busy_q, fetch_busy_d;

  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  seq_pc;

`ifndef IF_EXC_VECTOR_EN
  logic [32:0]  unused_exc;
  assign unused_exc = {exc, EXC_VECTOR};
`endif

  if_next_pc u_next_pc (
    .pc            (pc_q),
`ifdef IF_EXC_VECTOR_EN
    .exc           (exc),
    .exc_vector    (EXC_VECTOR),
`endif
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .seq_pc        (seq_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    inst_d     = inst_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
        if (redirect) pc_d = redirect_pc;
      end
      ST_FETCH: begin
        // pc_q drives imem_addr, so it only moves once the response arrives.
        if (imem_ready) begin
          if (redirect) begin
            pc_d   = redirect_pc;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else begin
            inst_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          pend_d     = 1'b1;
          pend_tgt_d = redirect_pc;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (pc_write) begin
          pc_d    = seq_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_RST;
    endcase

    imem_req_d    = (state_d == ST_FETCH);
    fetch_busy_d  = (state_d != ST_HOLD);
    if_inst_d     = (state_d == ST_HOLD) ? inst_d : NOP;
    if_pc_plus4_d = (state_d == ST_HOLD) ? (pc_d + 32'd4) : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST;
      pc_q          <= word_align(RESET_PC);
      pend_q        <= 1'b0;
      pend_tgt_q    <= 32'h0;
      inst_q        <= NOP;
      if_inst_q     <= NOP;
      if_pc_plus4_q <= 32'h0;
      imem_req_q    <= 1'b0;
      fetch_busy_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_tgt_q    <= pend_tgt_d;
      inst_q        <= inst_d;
      if_inst_q     <= if_inst_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      imem_req_q    <= imem_req_d;
      fetch_busy_q  <= fetch_busy_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign IF_Inst     = if_inst_q;
  assign IF_PC_Plus4 = if_pc_plus4_q;
  assign fetch_busy  = fetch_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_if_fetch_unit: scoreboard bench for if_fetch_unit.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, pc_write, branch_taken, jump, exc;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ready, fetch_busy;
  logic [31:0] imem_addr, imem_rdata, IF_Inst, IF_PC_Plus4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] plus4;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_busy = 1'b1;

  if_fetch_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exc           (exc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .IF_Inst       (IF_Inst),
    .IF_PC_Plus4   (IF_PC_Plus4),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[31:2], 2'b11} ^ 32'h1357_0000;
  endfunction

  always_comb imem_rdata = mem_f(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.inst  = mem_f(addr);
    e.plus4 = addr + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold();
    int n = 0;
    @(negedge clk);
    while (fetch_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (fetch_busy) chk("hold_timeout", {31'b0, fetch_busy}, 32'h0);
  endtask

  // Each new entry into HOLD retires one expected instruction.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b1;
    end else begin
      if (prev_busy && !fetch_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst", IF_Inst, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("if_inst", IF_Inst, e.inst);
          chk("if_pc_plus4", IF_PC_Plus4, e.plus4);
        end
      end
      prev_busy = fetch_busy;
    end
  end

  initial begin
    logic [31:0] exc_pc;
    int holds;
    reset = 1'b1; pc_write = 1'b0; imem_ready = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; exc = 1'b0;
    repeat (2) step();

    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h1);
    chk("rst_inst", IF_Inst, 32'h0);
    chk("rst_plus4", IF_PC_Plus4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    push(32'h0);
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    wait_hold();

    // Stall in HOLD: outputs frozen, no request
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      chk("stall_inst", IF_Inst, 32'h2008_0005);
      chk("stall_plus4", IF_PC_Plus4, 32'h4);
    end

    pc_write = 1'b1;
    push(32'h4);
    step();
    pc_write = 1'b0;
    @(negedge clk);
    chk("seq_addr4", imem_addr, 32'h4);
    wait_hold();

    // Wait states at 8, then branch to 0x40 during the wait
    imem_ready = 1'b0;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_busy", {31'b0, fetch_busy}, 32'h1);
      chk("wait_inst", IF_Inst, 32'h0);
      step();
    end
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("pend_addr_held", imem_addr, 32'h8);
    imem_ready = 1'b1;
    push(32'h40);
    step();
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_busy", {31'b0, fetch_busy}, 32'h1);
    wait_hold();

    // Jump in the same cycle as imem_ready
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    jump = 1'b1; jump_target = 32'h100;
    push(32'h100);
    step();
    jump = 1'b0;
    @(negedge clk);
    chk("same_cyc_addr", imem_addr, 32'h100);
    wait_hold();

    // All redirect sources at once
`ifdef IF_EXC_VECTOR_EN
    exc_pc = 32'h8000_0004;
`else
    exc_pc = 32'h200;
`endif
    exc = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    push(exc_pc);
    step();
    exc = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    @(negedge clk);
    chk("prio_addr", imem_addr, exc_pc);
    wait_hold();

    // PC wrap
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC);
    step();
    jump = 1'b0;
    @(negedge clk);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    wait_hold();
    pc_write = 1'b1;
    push(32'h0);
    step();
    pc_write = 1'b0;
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    wait_hold();

    // Reset with a request outstanding, late ready ignored
    imem_ready = 1'b0;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", imem_addr, 32'h4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    chk("midrst_busy", {31'b0, fetch_busy}, 32'h1);
    chk("midrst_addr", imem_addr, 32'h0);
    push(32'h0);
    step();
    @(negedge clk);
    chk("refetch_req", {31'b0, imem_req}, 32'h1);
    wait_hold();

    // Zero-wait throughput: one instruction per two cycles
    push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    pc_write = 1'b1;
    holds = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 7) pc_write = 1'b0;
      @(negedge clk);
      if (!fetch_busy) holds++;
    end
    chk("throughput", holds, 32'd4);

    repeat (2) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
